// File: rtl/calc_display_ctrl_if.sv
// Digit stream from the calculator core: status, BCD data and slot position.
interface calc_display_ctrl_if;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;

  modport master (output status, output data, output pos);
  modport slave  (input  status, input  data, input  pos);
endinterface

// File: rtl/calc_display_ctrl.sv
// Captures calculator print frames into a shadow buffer, commits them atomically
// and scans eight common-anode 7-segment digits with blanking and an error banner.
module calc_display_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  calc_display_ctrl_if.slave  stream,
  output logic [7:0]          an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                busy_led,
  output logic                frame_done
);

  localparam logic [1:0] ST_ERROR = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;
  localparam logic [1:0] ST_PRINT = 2'b11;

  localparam int             DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_O     = 7'h23;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    bcd_to_seg = 7'h40;
      4'd1:    bcd_to_seg = 7'h79;
      4'd2:    bcd_to_seg = 7'h24;
      4'd3:    bcd_to_seg = 7'h30;
      4'd4:    bcd_to_seg = 7'h19;
      4'd5:    bcd_to_seg = 7'h12;
      4'd6:    bcd_to_seg = 7'h02;
      4'd7:    bcd_to_seg = 7'h78;
      4'd8:    bcd_to_seg = 7'h00;
      4'd9:    bcd_to_seg = 7'h10;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

  logic [1:0]       status_q;
  logic [7:0][3:0]  shadow_q, shadow_d;
  logic [7:0][3:0]  disp_q;
  logic             err_q;
  logic [2:0]       idx_q;
  logic [DIV_W-1:0] div_q;
  logic [7:0]       an_q;
  logic [6:0]       seg_q, seg_d;
  logic             busy_q;
  logic             done_q;

  logic       frame_start;
  logic       digit_wr;
  logic       commit;
  logic [2:0] wr_idx;
  logic [7:0] lit;

  assign frame_start = (stream.status == ST_PRINT) && (status_q != ST_PRINT);
  assign digit_wr    = (stream.status == ST_PRINT) && (stream.pos != 4'd0) && (stream.pos <= 4'd8);
  assign commit      = (status_q == ST_PRINT) && (stream.status == ST_READY);
  assign wr_idx      = 3'(stream.pos - 4'd1);

  // An aborted frame leaves stale shadow contents; the next frame start clears them.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      shadow_d[i] = frame_start ? 4'd0 : shadow_q[i];
      if (digit_wr && (wr_idx == i[2:0])) shadow_d[i] = stream.data;
    end
  end

  // A digit stays lit once any digit at or above it is nonzero.
  always_comb begin
    logic any_nz;
    any_nz = 1'b0;
    lit    = '0;
    for (int k = 7; k >= 0; k--) begin
      any_nz = any_nz || (disp_q[k] != 4'd0);
      lit[k] = any_nz || (k == 0) || !BLANK_LZ;
    end
  end

  always_comb begin
    seg_d = SEG_BLANK;
    if (err_q) begin
      case (idx_q)
        3'd3:         seg_d = SEG_E;
        3'd2, 3'd1:   seg_d = SEG_R;
        3'd0:         seg_d = SEG_O;
        default:      seg_d = SEG_BLANK;
      endcase
    end else if (lit[idx_q]) begin
      seg_d = bcd_to_seg(disp_q[idx_q]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status_q <= ST_READY;
      shadow_q <= '0;
      disp_q   <= '0;
      err_q    <= 1'b0;
      idx_q    <= 3'd0;
      div_q    <= '0;
      an_q     <= 8'hFF;
      seg_q    <= SEG_BLANK;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      status_q <= stream.status;
      shadow_q <= shadow_d;
      if (commit) begin
        disp_q <= shadow_q;
        err_q  <= 1'b0;
      end else if (stream.status == ST_ERROR) begin
        err_q  <= 1'b1;
      end
      done_q <= commit;
      busy_q <= (stream.status == ST_BUSY);
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        div_q <= div_q + 1'b1;
      end
      // Scan outputs lag the index/buffer by one cycle.
      an_q  <= ~(8'b1 << idx_q);
      seg_q <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign busy_led   = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Bench for calc_display_ctrl: cycle-by-cycle reference model, decode table and
// hand sequences, with BLANK_LZ=1 and BLANK_LZ=0 instances on one stream.
module tb_calc_display_ctrl;
  localparam int SD = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  calc_display_ctrl_if bus();

  logic [7:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, busy_a, busy_b, done_a, done_b;

  calc_display_ctrl #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
    .clock(clock), .reset(reset), .stream(bus),
    .an(an_a), .seg(seg_a), .dp(dp_a), .busy_led(busy_a), .frame_done(done_a));

  calc_display_ctrl #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_nb (
    .clock(clock), .reset(reset), .stream(bus),
    .an(an_b), .seg(seg_b), .dp(dp_b), .busy_led(busy_b), .frame_done(done_b));

  typedef struct packed {
    logic [3:0] digit;
    logic [6:0] seg;
  } vec_t;

  vec_t vecs[16];
  int   digseg[10];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  int m_prev;
  int m_shadow[8];
  int m_disp[8];
  bit m_err;
  int m_cyc;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int model_seg(input int k, input bit lz);
    int msd;
    if (m_err) begin
      if (k == 3) return 'h06;
      if (k == 2 || k == 1) return 'h2F;
      if (k == 0) return 'h23;
      return 'h7F;
    end
    msd = 0;
    for (int j = 0; j < 8; j++) if (m_disp[j] != 0) msd = j;
    if (lz && k > msd) return 'h7F;
    if (m_disp[k] > 9) return 'h7F;
    return digseg[m_disp[k]];
  endfunction

  task automatic model_reset();
    m_prev = 2;
    m_err  = 1'b0;
    m_cyc  = 0;
    for (int j = 0; j < 8; j++) begin
      m_shadow[j] = 0;
      m_disp[j]   = 0;
    end
  endtask

  task automatic drive(input int s, input int d, input int p);
    bus.status = 2'(s);
    bus.data   = 4'(d);
    bus.pos    = 4'(p);
  endtask

  // One clock: predict outputs from pre-edge model state, advance model, compare.
  task automatic step();
    int k, e_an, e_sa, e_sb, e_done, e_busy, s, p, d;
    k      = (m_cyc / SD) % 8;
    e_an   = (~(1 << k)) & 255;
    e_sa   = model_seg(k, 1'b1);
    e_sb   = model_seg(k, 1'b0);
    s      = int'(bus.status);
    p      = int'(bus.pos);
    d      = int'(bus.data);
    e_done = (m_prev == 3 && s == 2) ? 1 : 0;
    e_busy = (s == 1) ? 1 : 0;
    if (s == 3) begin
      if (m_prev != 3) for (int j = 0; j < 8; j++) m_shadow[j] = 0;
      if (p >= 1 && p <= 8) m_shadow[p-1] = d;
    end
    if (m_prev == 3 && s == 2) begin
      m_disp = m_shadow;
      m_err  = 1'b0;
    end
    if (s == 0) m_err = 1'b1;
    m_prev = s;
    m_cyc++;
    @(posedge clock); #1;
    chk("an_lz", an_a, e_an);
    chk("an_nolz", an_b, e_an);
    chk("seg_lz", seg_a, e_sa);
    chk("seg_nolz", seg_b, e_sb);
    chk("frame_done", done_a, e_done);
    chk("frame_done_nolz", done_b, e_done);
    chk("busy_led", busy_a, e_busy);
    chk("busy_led_nolz", busy_b, e_busy);
    chk("dp", {dp_a, dp_b}, 3);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until digit k is being scanned; return both instances' segments.
  task automatic show(input int k, output int sa, output int sb);
    logic [7:0] tgt;
    int guard;
    tgt   = ~(8'b1 << k);
    guard = 0;
    while (an_a != tgt && guard < 40) begin
      step();
      guard++;
    end
    if (an_a != tgt) chk("scan_timeout", an_a, tgt);
    sa = seg_a;
    sb = seg_b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_an", an_a, 'hFF);
    chk("rst_seg", seg_a, 'h7F);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    @(posedge clock); #1;
    chk("rst_hold_an", an_b, 'hFF);
    drive(2, 0, 0);
    reset = 1'b0;
  endtask

  task automatic frame3(input int d0, input int d1, input int d2);
    drive(3, d0, 1); step();
    drive(3, d1, 2); step();
    drive(3, d2, 3); step();
    drive(2, 0, 0);  step();
    step();
  endtask

  initial begin
    int sa, sb;
    vecs = '{ '{4'd0, 7'h40}, '{4'd1, 7'h79}, '{4'd2, 7'h24}, '{4'd3, 7'h30},
              '{4'd4, 7'h19}, '{4'd5, 7'h12}, '{4'd6, 7'h02}, '{4'd7, 7'h78},
              '{4'd8, 7'h00}, '{4'd9, 7'h10}, '{4'd10, 7'h7F}, '{4'd11, 7'h7F},
              '{4'd12, 7'h7F}, '{4'd13, 7'h7F}, '{4'd14, 7'h7F}, '{4'd15, 7'h7F} };
    digseg = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};
    drive(2, 0, 0);
    #2;
    do_reset();

    // Idle scan after reset: "0" on digit 0 only
    steps(36);
    show(0, sa, sb); chk("idle_d0", sa, 'h40);
    show(5, sa, sb); chk("idle_d5", sa, 'h7F); chk("idle_d5_nolz", sb, 'h40);

    // "123" with a single frame_done pulse
    drive(3, 3, 1); step();
    drive(3, 2, 2); step();
    drive(3, 1, 3); step();
    drive(2, 0, 0); step();
    chk("done_pulse", done_a, 1);
    step();
    chk("done_single", done_a, 0);
    show(0, sa, sb); chk("123_d0", sa, 'h30);
    show(1, sa, sb); chk("123_d1", sa, 'h24);
    show(2, sa, sb); chk("123_d2", sa, 'h79);
    show(3, sa, sb); chk("123_d3", sa, 'h7F);

    // Error banner, then cleared by the next commit
    drive(0, 0, 0); step();
    drive(2, 0, 0); step(); step();
    show(3, sa, sb); chk("err_d3", sa, 'h06);
    show(4, sa, sb); chk("err_d4", sa, 'h7F);
    show(0, sa, sb); chk("err_d0", sa, 'h23);
    show(1, sa, sb); chk("err_d1", sa, 'h2F);
    drive(3, 7, 1); step();
    drive(2, 0, 0); step(); step();
    show(0, sa, sb); chk("seven_d0", sa, 'h78);
    show(1, sa, sb); chk("seven_d1", sa, 'h7F);

    // "50": interior zero kept, leading zeros blanked only with BLANK_LZ
    frame3(0, 5, 0);
    show(0, sa, sb); chk("fifty_d0", sa, 'h40);
    show(1, sa, sb); chk("fifty_d1", sa, 'h12);
    show(2, sa, sb); chk("fifty_d2", sa, 'h7F); chk("fifty_d2_nolz", sb, 'h40);
    show(7, sa, sb); chk("fifty_d7_nolz", sb, 'h40);

    // Aborted 8-digit frame plus out-of-range positions
    for (int i = 1; i <= 8; i++) begin drive(3, 9, i); step(); end
    drive(3, 4, 0); step();
    drive(3, 4, 9); step();
    drive(1, 0, 0); step();
    chk("abort_busy", busy_a, 1);
    drive(2, 0, 0); steps(3);
    show(1, sa, sb); chk("abort_keep_d1", sa, 'h12);
    show(2, sa, sb); chk("abort_keep_d2", sa, 'h7F);

    drive(3, 4, 2); step();
    drive(3, 9, 0); step();
    drive(3, 9, 9); step();
    drive(3, 5, 1); step();
    drive(3, 8, 1); step();
    drive(2, 0, 0); step(); step();
    show(0, sa, sb); chk("lastwins_d0", sa, 'h00);
    show(1, sa, sb); chk("pos_ok_d1", sa, 'h19);
    show(2, sa, sb); chk("pos_ignored_d2", sa, 'h7F);

    // Decode table on digit 0
    for (int i = 0; i < 16; i++) begin
      drive(3, int'(vecs[i].digit), 1); step();
      drive(2, 0, 0); step(); step();
      show(0, sa, sb);
      chk($sformatf("decode_%0d", i), sa, int'(vecs[i].seg));
    end

    // Randomized stream against the model
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      drive((r < 5) ? 3 : (r < 8) ? 2 : (r == 8) ? 1 : 0,
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      step();
    end

    // Reset mid-frame after four writes
    drive(2, 0, 0); steps(2);
    for (int i = 1; i <= 4; i++) begin drive(3, i + 4, i); step(); end
    #2;
    do_reset();
    steps(3);
    show(0, sa, sb); chk("post_rst_d0", sa, 'h40);
    show(1, sa, sb); chk("post_rst_d1", sa, 'h7F); chk("post_rst_d1_nolz", sb, 'h40);
    show(3, sa, sb); chk("post_rst_d3", sa, 'h7F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
